// File: rtl/ped_request_ctrl.sv
// Pedestrian request front end for the traffic controller.
// Each road's push-button is synchronised and debounced. The resulting request is
// latched until the controller acknowledges it. A request is flagged urgent after
// MAX_WAIT one-second ticks. ctrl_enable wakes the controller on demand or in auto mode.
module ped_request_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_BITS   = 20,
    parameter int MAX_WAIT   = 30,
    parameter int WAIT_BITS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic [1:0] btn_raw,
    input  logic [1:0] walk_ack,
    input  logic       auto_mode,
    output logic [1:0] req_pending,
    output logic [1:0] urgent,
    output logic       ctrl_enable
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PENDING  = 2'd2,
        SERVED   = 2'd3
    } road_state_e;

    localparam logic [DEB_BITS-1:0]  DEB_LAST = DEB_BITS'(DEB_CYCLES - 1);
    localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(MAX_WAIT);

    logic [1:0]           sync_meta_q, sync_meta_d;
    logic [1:0]           sync_q, sync_d;
    road_state_e          state_q [2];
    road_state_e          state_d [2];
    logic [DEB_BITS-1:0]  deb_cnt_q [2];
    logic [DEB_BITS-1:0]  deb_cnt_d [2];
    logic [WAIT_BITS-1:0] wait_cnt_q [2];
    logic [WAIT_BITS-1:0] wait_cnt_d [2];
    logic [1:0]           req_pending_q, req_pending_d;
    logic [1:0]           urgent_q, urgent_d;
    logic                 ctrl_enable_q, ctrl_enable_d;

    // Two-flop synchroniser chain for the raw asynchronous buttons
    always_comb begin
        sync_meta_d = btn_raw;
        sync_d      = sync_meta_q;
    end

    // Per-road request FSM: debounce the press, hold the request, then require a stable release
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i]    = state_q[i];
            deb_cnt_d[i]  = deb_cnt_q[i];
            wait_cnt_d[i] = wait_cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync_q[i]) begin
                        state_d[i]   = DEBOUNCE;
                        deb_cnt_d[i] = DEB_BITS'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!sync_q[i]) begin
                        state_d[i]   = IDLE;
                        deb_cnt_d[i] = '0;
                    end else if (deb_cnt_q[i] == DEB_LAST) begin
                        state_d[i]   = PENDING;
                        deb_cnt_d[i] = '0;
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + DEB_BITS'(1);
                    end
                end
                PENDING: begin
                    if (walk_ack[i]) begin
                        state_d[i]    = SERVED;
                        wait_cnt_d[i] = '0;
                    end else if (tick_1s && (wait_cnt_q[i] != WAIT_MAX)) begin
                        wait_cnt_d[i] = wait_cnt_q[i] + WAIT_BITS'(1);
                    end
                end
                SERVED: begin
                    if (sync_q[i]) begin
                        deb_cnt_d[i] = '0;
                    end else if (deb_cnt_q[i] == DEB_LAST) begin
                        state_d[i]   = IDLE;
                        deb_cnt_d[i] = '0;
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + DEB_BITS'(1);
                    end
                end
                default: begin
                    state_d[i]    = IDLE;
                    deb_cnt_d[i]  = '0;
                    wait_cnt_d[i] = '0;
                end
            endcase
        end
    end

    // Registered outputs come from the next state, so they change on the same edge as the FSM
    always_comb begin
        req_pending_d = 2'b00;
        urgent_d      = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_pending_d[i] = (state_d[i] == PENDING);
            urgent_d[i]      = (state_d[i] == PENDING) && (wait_cnt_d[i] == WAIT_MAX);
        end
        ctrl_enable_d = auto_mode | req_pending_q[0] | req_pending_q[1];
    end

    // State register; reset drops every request immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_q   <= 2'b00;
            sync_q        <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                state_q[i]    <= IDLE;
                deb_cnt_q[i]  <= '0;
                wait_cnt_q[i] <= '0;
            end
            req_pending_q <= 2'b00;
            urgent_q      <= 2'b00;
            ctrl_enable_q <= 1'b0;
        end else begin
            sync_meta_q   <= sync_meta_d;
            sync_q        <= sync_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i]    <= state_d[i];
                deb_cnt_q[i]  <= deb_cnt_d[i];
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
            req_pending_q <= req_pending_d;
            urgent_q      <= urgent_d;
            ctrl_enable_q <= ctrl_enable_d;
        end
    end

    assign req_pending = req_pending_q;
    assign urgent      = urgent_q;
    assign ctrl_enable = ctrl_enable_q;

endmodule
